hilo_muldiv_ctrl: RTL and testbench

//   Iterative multiply/divide sequencer that owns all writes to the HI/LO register pair.

---
 rtl/hilo_muldiv_if.sv | 27 ++
 rtl/hilo_muldiv_ctrl.sv | 137 +++++++++++++
 tb/tb_hilo_muldiv_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/hilo_muldiv_if.sv
// EX-stage <-> HI/LO mul/div sequencer handshake bundle.
// The master side is the pipeline front end and the slave side is the sequencer.
interface hilo_muldiv_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             flush;
  logic             mfhilo_req;
  logic             busy;
  logic             stall;
  logic             hilo_we;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;

  modport master (
    output start, op, rs_val, rt_val, flush, mfhilo_req,
    input  busy, stall, hilo_we, hi_out, lo_out
  );

  modport slave (
    input  start, op, rs_val, rt_val, flush, mfhilo_req,
    output busy, stall, hilo_we, hi_out, lo_out
  );
endinterface

// File: rtl/hilo_muldiv_ctrl.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU sequencer owning all HI/LO writes.
// It runs one shift-add or restoring-subtract step per cycle and commits the result with a single-cycle strobe.
module hilo_muldiv_ctrl #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input logic          clk,
  input logic          rst,
  hilo_muldiv_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               is_div;
  logic               neg_hi;
  logic               neg_lo;
  logic               div_zero;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   mq;
  logic [WIDTH-1:0]   opnd;

  logic               signed_op;
  logic               rs_neg;
  logic               rt_neg;
  logic [WIDTH-1:0]   rs_abs;
  logic [WIDTH-1:0]   rt_abs;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh;
  logic               div_ge;
  logic [WIDTH-1:0]   acc_nxt;
  logic [WIDTH-1:0]   mq_nxt;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   hi_fix;
  logic [WIDTH-1:0]   lo_fix;

  // Operands are reduced to magnitudes; signs are re-applied at commit.
  assign signed_op = ~bus.op[0];
  assign rs_neg    = signed_op & bus.rs_val[WIDTH-1];
  assign rt_neg    = signed_op & bus.rt_val[WIDTH-1];
  assign rs_abs    = rs_neg ? -bus.rs_val : bus.rs_val;
  assign rt_abs    = rt_neg ? -bus.rt_val : bus.rt_val;

  // One iteration: acc/mq hold partial product (mul) or remainder/quotient (div).
  always_comb begin
    mul_sum = '0;
    div_sh  = '0;
    div_ge  = 1'b0;
    acc_nxt = acc;
    mq_nxt  = mq;
    if (is_div) begin
      div_sh  = {acc, mq[WIDTH-1]};
      div_ge  = (div_sh >= {1'b0, opnd});
      acc_nxt = div_ge ? WIDTH'(div_sh - {1'b0, opnd}) : div_sh[WIDTH-1:0];
      mq_nxt  = {mq[WIDTH-2:0], div_ge};
    end else begin
      mul_sum = {1'b0, acc} + ({1'b0, opnd} & {(WIDTH + 1){mq[0]}});
      acc_nxt = mul_sum[WIDTH:1];
      mq_nxt  = {mul_sum[0], mq[WIDTH-1:1]};
    end
  end

  // Sign correction of the final step; a zero divisor forces an all-ones quotient.
  always_comb begin
    prod_fix = neg_lo ? -{acc_nxt, mq_nxt} : {acc_nxt, mq_nxt};
    hi_fix   = neg_hi ? -acc_nxt : acc_nxt;
    lo_fix   = div_zero ? '1 : (neg_lo ? -mq_nxt : mq_nxt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      is_div     <= 1'b0;
      neg_hi     <= 1'b0;
      neg_lo     <= 1'b0;
      div_zero   <= 1'b0;
      acc        <= '0;
      mq         <= '0;
      opnd       <= '0;
      bus.busy   <= 1'b0;
      bus.hi_out <= '0;
      bus.lo_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start && !bus.flush) begin
            state    <= CALC;
            bus.busy <= 1'b1;
            cnt      <= '0;
            is_div   <= bus.op[1];
            neg_lo   <= rs_neg ^ rt_neg;
            neg_hi   <= bus.op[1] ? rs_neg : (rs_neg ^ rt_neg);
            div_zero <= bus.op[1] & (bus.rt_val == '0);
            acc      <= '0;
            mq       <= rs_abs;
            opnd     <= rt_abs;
          end
        end
        CALC: begin
          if (bus.flush) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end else begin
            acc <= acc_nxt;
            mq  <= mq_nxt;
            if (cnt == CNT_W'(WIDTH - 1)) begin
              state      <= DONE;
              bus.hi_out <= is_div ? hi_fix : prod_fix[2*WIDTH-1:WIDTH];
              bus.lo_out <= is_div ? lo_fix : prod_fix[WIDTH-1:0];
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

  // A flush in the DONE cycle must suppress the commit in that same cycle.
  assign bus.hilo_we = (state == DONE) & ~bus.flush;
  assign bus.stall   = bus.busy & (bus.start | bus.mfhilo_req);

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Scoreboard bench for hilo_muldiv_ctrl: expected HI/LO and commit cycle are queued at issue.
// A negedge monitor pops them on every write strobe.
module tb_hilo_muldiv_ctrl;
  localparam int unsigned W   = 32;
  localparam int unsigned LAT = W + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned cyc = 0;
  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [63:0] res;
    int unsigned due;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  hilo_muldiv_if #(.WIDTH(W)) bus();

  hilo_muldiv_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb_v, q, r;
    logic [63:0] p;
    sa   = {{32{a[31]}}, a};
    sb_v = {{32{b[31]}}, b};
    p    = '0;
    case (op)
      2'd0: p = sa * sb_v;
      2'd1: p = {32'd0, a} * {32'd0, b};
      2'd2: begin
        if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb_v;
          r = sa % sb_v;
          p = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
        else p = {a % b, a / b};
      end
    endcase
    return p;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int unsigned c);
    while (cyc < c) next_cycle();
  endtask

  // Present one start for a single cycle in the current cycle.
  task automatic drive_start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit push);
    exp_t e;
    bus.start  = 1'b1;
    bus.op     = op;
    bus.rs_val = a;
    bus.rt_val = b;
    if (push) begin
      e.res = model(op, a, b);
      e.due = cyc + LAT;
      sb.push_back(e);
    end
    next_cycle();
    bus.start  = 1'b0;
    bus.rs_val = $urandom;
    bus.rt_val = $urandom;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) next_cycle();
    check_eq("drain", 64'(sb.size()), 64'd0);
    next_cycle();
  endtask

  always @(negedge clk) begin
    if (!rst && bus.hilo_we === 1'b1) begin
      if (sb.size() == 0) begin
        check_eq("spurious_we", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check_eq("hilo", {bus.hi_out, bus.lo_out}, mon_e.res);
        check_eq("latency", 64'(cyc), 64'(mon_e.due));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int unsigned t;
    bus.start      = 1'b0;
    bus.op         = 2'd0;
    bus.rs_val     = '0;
    bus.rt_val     = '0;
    bus.flush      = 1'b0;
    bus.mfhilo_req = 1'b0;
    repeat (3) next_cycle();
    @(negedge clk);
    check_eq("rst_busy",  64'(bus.busy), 64'd0);
    check_eq("rst_stall", 64'(bus.stall), 64'd0);
    check_eq("rst_we",    64'(bus.hilo_we), 64'd0);
    check_eq("rst_hilo",  {bus.hi_out, bus.lo_out}, 64'd0);
    next_cycle();
    rst = 1'b0;
    next_cycle();

    // Directed corner cases.
    drive_start(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1); wait_drain();
    drive_start(2'd0, 32'hFFFF_FFFD, 32'd5, 1'b1);         wait_drain();
    drive_start(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b1);         wait_drain();
    drive_start(2'd3, 32'h0000_1234, 32'd0, 1'b1);         wait_drain();
    drive_start(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1); wait_drain();
    drive_start(2'd2, 32'hFFFF_FFF0, 32'd0, 1'b1);         wait_drain();
    drive_start(2'd0, 32'h8000_0000, 32'h8000_0000, 1'b1); wait_drain();

    // Random mix of all four ops, some with zero or small divisors.
    for (int i = 0; i < 10; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = (i % 4 == 0) ? 32'd0 : ((i % 4 == 1) ? 32'($urandom_range(1, 9)) : $urandom);
      drive_start(2'($urandom_range(0, 3)), a, b, 1'b1);
      wait_drain();
    end

    // MFHI/MFLO held while busy stalls through the DONE cycle.
    t = cyc;
    drive_start(2'd1, 32'd100, 32'd7, 1'b1);
    wait_until(t + 5);
    bus.mfhilo_req = 1'b1;
    while (cyc <= t + 34) begin
      @(negedge clk);
      check_eq("stall_mf", 64'(bus.stall), 64'(cyc <= t + 33));
      next_cycle();
    end
    bus.mfhilo_req = 1'b0;
    wait_drain();

    // Start while busy is held off and accepted the cycle after DONE.
    t = cyc;
    drive_start(2'd3, 32'd1000, 32'd7, 1'b1);
    wait_until(t + 10);
    bus.start  = 1'b1;
    bus.op     = 2'd0;
    bus.rs_val = 32'hFFFF_FF00;
    bus.rt_val = 32'h0000_0123;
    while (cyc <= t + 34) begin
      @(negedge clk);
      check_eq("stall_busy", 64'(bus.stall), 64'(cyc <= t + 33));
      if (cyc == t + 34) begin
        exp_t e;
        e.res = model(2'd0, 32'hFFFF_FF00, 32'h0000_0123);
        e.due = cyc + LAT;
        sb.push_back(e);
      end
      next_cycle();
    end
    bus.start = 1'b0;
    wait_drain();

    // Flush during CALC aborts with no commit.
    t = cyc;
    drive_start(2'd0, 32'd9, 32'd9, 1'b0);
    wait_until(t + 10);
    bus.flush = 1'b1;
    next_cycle();
    bus.flush = 1'b0;
    @(negedge clk);
    check_eq("flush_calc_busy", 64'(bus.busy), 64'd0);
    repeat (40) next_cycle();

    // Flush in the DONE cycle suppresses the strobe in that cycle.
    t = cyc;
    drive_start(2'd1, 32'd3, 32'd4, 1'b0);
    wait_until(t + 33);
    bus.flush = 1'b1;
    @(negedge clk);
    check_eq("flush_done_busy", 64'(bus.busy), 64'd1);
    check_eq("flush_done_we", 64'(bus.hilo_we), 64'd0);
    next_cycle();
    bus.flush = 1'b0;
    @(negedge clk);
    check_eq("flush_done_idle", 64'(bus.busy), 64'd0);
    repeat (5) next_cycle();

    // Start together with flush in IDLE is ignored.
    bus.flush = 1'b1;
    drive_start(2'd1, 32'd5, 32'd6, 1'b0);
    bus.flush = 1'b0;
    @(negedge clk);
    check_eq("start_flush_idle", 64'(bus.busy), 64'd0);
    repeat (40) next_cycle();

    // Reset mid-operation discards everything.
    t = cyc;
    drive_start(2'd1, 32'd77, 32'd88, 1'b0);
    wait_until(t + 20);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_mid_busy", 64'(bus.busy), 64'd0);
    check_eq("rst_mid_we", 64'(bus.hilo_we), 64'd0);
    check_eq("rst_mid_hilo", {bus.hi_out, bus.lo_out}, 64'd0);
    repeat (40) next_cycle();

    // Back-to-back accepts after a reset still work.
    drive_start(2'd2, 32'd100, 32'hFFFF_FFF9, 1'b1);
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
